// File: rtl/button_debounce.sv
// Per-button 2-flop synchronizer, stability counter, clean level and edge pulses.
// Define BUTTON_DEBOUNCE_REPEAT_EN to add auto-repeat pulses on btn_pdg while held.
module button_debounce #(
    parameter int BTN  = 2,
    parameter int DBPN = 5,
    parameter int DBPL = $clog2(DBPN + 1)
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
    ,
    parameter int RPDN = 20,
    parameter int RPPN = 8
`endif
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [BTN-1:0] btn_i,
    output logic [BTN-1:0] btn_o,
    output logic [BTN-1:0] btn_pdg,
    output logic [BTN-1:0] btn_ndg
);

    logic [BTN-1:0]  s1_q, s2_q;
    logic [BTN-1:0]  lvl_q, lvl_d;
    logic [BTN-1:0]  pdg_q, pdg_d;
    logic [BTN-1:0]  ndg_q, ndg_d;
    logic [DBPL-1:0] cnt_q [BTN];
    logic [DBPL-1:0] cnt_d [BTN];

`ifdef BUTTON_DEBOUNCE_REPEAT_EN
    localparam int RPMX = (RPDN > RPPN) ? RPDN : RPPN;
    localparam int RPL  = $clog2(RPMX + 1);

    logic [RPL-1:0] rcnt_q [BTN];
    logic [RPL-1:0] rcnt_d [BTN];
    logic [BTN-1:0] rfst_q, rfst_d;
    logic [BTN-1:0] rpt;
`endif

    always_comb begin
        lvl_d = lvl_q;
        for (int i = 0; i < BTN; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != lvl_q[i]) begin
                if (cnt_q[i] == DBPL'(DBPN - 1)) begin
                    lvl_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        pdg_d = lvl_d & ~lvl_q;
        ndg_d = ~lvl_d & lvl_q;
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
        // rfst selects the initial delay until the first repeat has fired
        for (int i = 0; i < BTN; i++) begin
            rcnt_d[i] = '0;
            rfst_d[i] = 1'b1;
            rpt[i]    = 1'b0;
            if (lvl_q[i] && lvl_d[i]) begin
                rfst_d[i] = rfst_q[i];
                rcnt_d[i] = rcnt_q[i] + 1'b1;
                if (rcnt_d[i] == (rfst_q[i] ? RPL'(RPDN) : RPL'(RPPN))) begin
                    rpt[i]    = 1'b1;
                    rcnt_d[i] = '0;
                    rfst_d[i] = 1'b0;
                end
            end
        end
        pdg_d = pdg_d | rpt;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= '0;
            s2_q   <= '0;
            lvl_q  <= '0;
            pdg_q  <= '0;
            ndg_q  <= '0;
            cnt_q  <= '{default: '0};
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
            rcnt_q <= '{default: '0};
            rfst_q <= '1;
`endif
        end else begin
            s1_q   <= btn_i;
            s2_q   <= s1_q;
            lvl_q  <= lvl_d;
            pdg_q  <= pdg_d;
            ndg_q  <= ndg_d;
            cnt_q  <= cnt_d;
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
            rcnt_q <= rcnt_d;
            rfst_q <= rfst_d;
`endif
        end
    end

    assign btn_o   = lvl_q;
    assign btn_pdg = pdg_q;
    assign btn_ndg = ndg_q;

endmodule
